sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Owns the single external 512Kx8 asynchronous SRAM and shares it between three masters: the boot loader (flash-to-SRAM copier, exclusive while `prog`=1), the video fetch unit and the CPU. It sits between those masters and the SRAM pins. It generates address, data, WE#, OE# and data-bus direction with a configurable number of access cycles. It grants video over CPU with a fairness limit.

## Interface
- `AW`, 19, SRAM address width.
- `WAIT`, 2, ACCESS-state cycles per access; legal range 2..7.
- `ROM_LO`, 19'h0F800, first address of the monitor ROM image.
- `ROM_HI`, 19'h0FFFF, last address of the monitor ROM image.

Ports:
- `clk` in 1, system clock.
- `rst` in 1, reset, asynchronous, active-low.
- `prog` in 1, loader owns the bus.
- `ld_add` in AW, loader address.
- `ld_do` in 8, loader write data.
- `ld_we` in 1, loader write strobe, active-low.
- `vid_req` in 1, video read request (level).
- `vid_addr` in AW, video read address.
- `vid_rdata` out 8, video read data.
- `vid_ack` out 1, one-cycle completion pulse.
- `cpu_req` in 1, CPU request (level).
- `cpu_we` in 1, 1 = write.
- `cpu_addr` in AW, CPU address.
- `cpu_wdata` in 8, CPU write data.
- `cpu_rdata` out 8, CPU read data.
- `cpu_ack` out 1, one-cycle completion pulse.
- `sram_addr` out AW, SRAM address.
- `sram_dout` out 8, data driven to the SRAM.
- `sram_din` in 8, data read from the SRAM.
- `sram_we_n` out 1, SRAM WE#.
- `sram_oe_n` out 1, SRAM OE#.
- `sram_dq_oe` out 1, 1 = FPGA drives DQ.

## Operation
- **Reset values:**
  - `sram_addr`=0, `sram_dout`=0
  - `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0
  - both acks 0, both rdata 0
  - state IDLE, `vid_streak`=0
- **States:** IDLE, ACCESS, DONE, TURN.
- **IDLE:**
  - If `prog`=1: pass the loader through combinationally.
    - `sram_addr`=`ld_add`, `sram_dout`=`ld_do`, `sram_we_n`=`ld_we`.
    - `sram_oe_n`=1, `sram_dq_oe`=1.
    - No grants.
  - Otherwise grant in this order:
    - If `vid_req` and (`vid_streak`<2 or !`cpu_req`): grant video and increment `vid_streak` (saturating at 3).
    - Else if `cpu_req`: grant CPU and clear `vid_streak`.
  - On a grant, register the address, data and type, then go to ACCESS with the cycle counter set to WAIT-1.
- **ACCESS (WAIT cycles):**
  - Read: `sram_oe_n`=0, `sram_dq_oe`=0. At the last ACCESS cycle, latch `sram_din` into the granted master's rdata.
  - Write: `sram_dq_oe`=1 for every cycle. `sram_we_n`=0 in every ACCESS cycle except the first (address setup).
- **DONE (1 cycle):**
  - Pulse the granted master's ack. Rdata is already valid.
  - Next state is TURN after a write, IDLE after a read.
- **TURN (1 cycle, write only):**
  - `sram_we_n`=1, `sram_dq_oe`=1, address and data held (hold time).
  - Next state IDLE.
- **Requester contract:**
  - Hold req and its address/data stable until ack.
  - Drop req (or present the next request) on the edge that ends the ack cycle.
  - The arbiter never issues ack to a master without a grant.
- **`prog` boundary conditions:**
  - `prog` rising mid-access: the in-flight access completes normally (ack issued). Loader passthrough starts on return to IDLE.
  - `prog` falling: arbitration resumes in the same IDLE cycle.
- **Simultaneous video and CPU requests:** video wins, except after 2 consecutive video grants with the CPU waiting.
- **Reset mid-access:** returns immediately to reset values. No ack is issued.

## Timing
- Read latency: req seen in IDLE at cycle 0; ack and rdata in cycle WAIT+1. Back-to-back read throughput is WAIT+2 cycles per access.
- Write: ack in cycle WAIT+1. The next grant is possible at cycle WAIT+3.
- Worst-case CPU wait with video continuously requesting: 2 video reads + its own access.
- All outputs are registered except the loader passthrough mux.

## Configuration
- `SRAM_ROM_WP_EN` defined:
  - A CPU write with `cpu_addr` in [`ROM_LO`,`ROM_HI`] runs the full write timing and is acked.
  - `sram_we_n` stays 1 throughout, so the ROM image cannot be corrupted.
  - Loader writes are unaffected.
- `SRAM_ROM_WP_EN` undefined: all CPU writes reach the SRAM.

## Test plan
- **Reset and idle:** release reset with no requests → `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, acks 0 indefinitely.
- **CPU read, WAIT=2:** `sram_din`=8'hA5 at 19'h00123 → `sram_oe_n` low for 2 cycles, `cpu_ack` in cycle 3, `cpu_rdata`=8'hA5.
- **CPU write:** 8'h3C to 19'h00010 → `sram_we_n` low exactly 1 cycle, `sram_dq_oe` high 4 cycles, `cpu_ack` in cycle 3.
- **Contention:** `vid_req` and `cpu_req` held continuously → grant order V,V,C,V,V,C…; no ack ever arrives without a prior request.
- **Loader handoff:** `prog`=1 mid CPU read → CPU read acked, then SRAM pins follow `ld_*`; `cpu_req` is not acked until `prog`=0.
- **Write protect:** with `SRAM_ROM_WP_EN`, a CPU write to 19'h0F900 → `cpu_ack` pulses and `sram_we_n` never goes low; a write to 19'h0F7FF does assert `sram_we_n`.

Source files
------------

// File: rtl/sram_arbiter.sv
// Arbiter for one asynchronous 512Kx8 SRAM shared by the boot loader, video fetch and the CPU.
// Optional feature: define SRAM_ROM_WP_EN to block CPU writes into the monitor ROM image.
module sram_arbiter #(
    parameter int             AW     = 19,
    parameter int             WAIT   = 2,
    parameter logic [AW-1:0]  ROM_LO = 19'h0F800,
    parameter logic [AW-1:0]  ROM_HI = 19'h0FFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog,
    input  logic [AW-1:0] ld_add,
    input  logic [7:0]    ld_do,
    input  logic          ld_we,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_rdata,
    output logic          vid_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_dout,
    input  logic [7:0]    sram_din,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic          sram_dq_oe
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_TURN   = 2'd3;

    localparam logic [2:0] CNT_INIT = 3'(WAIT - 1);

`ifdef SRAM_ROM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic [1:0]    state;
    logic [2:0]    cnt;
    logic [1:0]    vid_streak;
    logic          g_vid;
    logic          g_we;
    logic          g_wp;
    logic [AW-1:0] addr_q;
    logic [7:0]    dout_q;
    logic          we_n_q;
    logic          oe_n_q;
    logic          dq_oe_q;

    logic grant_vid;
    logic grant_cpu;
    logic wp_hit;
    logic pass;

    // Video has priority until it has won twice in a row while the CPU was waiting.
    assign grant_vid = !prog && vid_req && ((vid_streak < 2'd2) || !cpu_req);
    assign grant_cpu = !prog && cpu_req && !grant_vid;
    assign wp_hit    = WP_ON && cpu_we && (cpu_addr >= ROM_LO) && (cpu_addr <= ROM_HI);
    assign pass      = (state == S_IDLE) && prog;

    assign sram_addr  = pass ? ld_add : addr_q;
    assign sram_dout  = pass ? ld_do  : dout_q;
    assign sram_we_n  = pass ? ld_we  : we_n_q;
    assign sram_oe_n  = pass ? 1'b1   : oe_n_q;
    assign sram_dq_oe = pass ? 1'b1   : dq_oe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            vid_streak <= 2'd0;
            g_vid      <= 1'b0;
            g_we       <= 1'b0;
            g_wp       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= 8'd0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            vid_rdata  <= 8'd0;
            cpu_rdata  <= 8'd0;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vid) begin
                        state   <= S_ACCESS;
                        cnt     <= CNT_INIT;
                        g_vid   <= 1'b1;
                        g_we    <= 1'b0;
                        g_wp    <= 1'b0;
                        addr_q  <= vid_addr;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b0;
                        dq_oe_q <= 1'b0;
                        if (vid_streak != 2'd3) vid_streak <= vid_streak + 2'd1;
                    end else if (grant_cpu) begin
                        state      <= S_ACCESS;
                        cnt        <= CNT_INIT;
                        g_vid      <= 1'b0;
                        g_we       <= cpu_we;
                        g_wp       <= wp_hit;
                        addr_q     <= cpu_addr;
                        dout_q     <= cpu_wdata;
                        we_n_q     <= 1'b1;
                        oe_n_q     <= cpu_we;
                        dq_oe_q    <= cpu_we;
                        vid_streak <= 2'd0;
                    end
                end
                S_ACCESS: begin
                    if (cnt != 3'd0) begin
                        cnt    <= cnt - 3'd1;
                        // First ACCESS cycle is address setup; WE# strobes from the second on.
                        we_n_q <= !(g_we && !g_wp);
                    end else begin
                        state  <= S_DONE;
                        we_n_q <= 1'b1;
                        oe_n_q <= 1'b1;
                        if (g_vid) vid_ack <= 1'b1;
                        else       cpu_ack <= 1'b1;
                        if (!g_we) begin
                            if (g_vid) vid_rdata <= sram_din;
                            else       cpu_rdata <= sram_din;
                        end
                    end
                end
                S_DONE: begin
                    state <= g_we ? S_TURN : S_IDLE;
                end
                S_TURN: begin
                    state   <= S_IDLE;
                    dq_oe_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter (WAIT=2): cycle table for CPU read/write/loader, then hand-written
// sequences for loader handoff, write protect, video/CPU contention and reset mid-access.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        prog;
    logic [18:0] ld_add;
    logic [7:0]  ld_do;
    logic        ld_we;
    logic        vid_req;
    logic [18:0] vid_addr;
    logic [7:0]  vid_rdata;
    logic        vid_ack;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dout;
    logic [7:0]  sram_din;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_dq_oe;

    logic        use_model;
    logic [7:0]  din_tbl;

    int checks;
    int errors;

    logic [7:0] exp_q[$];

    // Simple SRAM read model: data is a fixed function of the address.
    assign sram_din = use_model ? (sram_addr[7:0] ^ 8'h5A) : din_tbl;

    sram_arbiter #(.AW(19), .WAIT(2)) dut (
        .clk(clk), .rst(rst), .prog(prog),
        .ld_add(ld_add), .ld_do(ld_do), .ld_we(ld_we),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_dq_oe(sram_dq_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        prog;
        logic [18:0] ld_add;
        logic [7:0]  ld_do;
        logic        ld_we;
        logic        req;
        logic        we;
        logic [18:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic [18:0] e_addr;
        logic [7:0]  e_dout;
        logic        e_we_n;
        logic        e_oe_n;
        logic        e_dq_oe;
        logic        e_ack;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after an edge; returns with the DUT back in IDLE.
    task automatic run_cpu(input logic we, input logic [18:0] a, input logic [7:0] d,
                           output int ack_at, output int we_low, output int dq_hi);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        ack_at = -1;
        we_low = 0;
        dq_hi  = 0;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (!sram_we_n) we_low++;
            if (sram_dq_oe) dq_hi++;
            if (cpu_ack) begin
                ack_at = i;
                break;
            end
            step();
        end
        step();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        #3;
        if (!sram_we_n) we_low++;
        if (sram_dq_oe) dq_hi++;
        step();
    endtask

    initial begin
        int ack_at, we_low, dq_hi, n_ack, got, dual;
        logic [7:0] code;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        prog = 1'b0; ld_add = '0; ld_do = '0; ld_we = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        use_model = 1'b0; din_tbl = 8'h00;

        //            prog ld_add     ld_do  ldwe req we addr       wdata  din    | e_addr     e_dout we_n oe_n dq ack rdata
        vecs[0]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b0, 1'b0, 19'h00000, 8'h00, 8'h00, 19'h00000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b1, 1'b0, 19'h00123, 8'h00, 8'hA5, 19'h00000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b1, 1'b0, 19'h00123, 8'h00, 8'hA5, 19'h00123, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b1, 1'b0, 19'h00123, 8'h00, 8'hA5, 19'h00123, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b1, 1'b0, 19'h00123, 8'h00, 8'hA5, 19'h00123, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
        vecs[5]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b0, 1'b0, 19'h00123, 8'h00, 8'h00, 19'h00123, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[6]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b1, 1'b1, 19'h00010, 8'h3C, 8'h00, 19'h00123, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b1, 1'b1, 19'h00010, 8'h3C, 8'h00, 19'h00010, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[8]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b1, 1'b1, 19'h00010, 8'h3C, 8'h00, 19'h00010, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[9]  = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b1, 1'b1, 19'h00010, 8'h3C, 8'h00, 19'h00010, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5};
        vecs[10] = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b0, 1'b0, 19'h00010, 8'h00, 8'h00, 19'h00010, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[11] = '{1'b0, 19'h00000, 8'h00, 1'b1, 1'b0, 1'b0, 19'h00010, 8'h00, 8'h00, 19'h00010, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[12] = '{1'b1, 19'h05555, 8'h77, 1'b0, 1'b0, 1'b0, 19'h00000, 8'h00, 8'h00, 19'h05555, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[13] = '{1'b1, 19'h05555, 8'h78, 1'b1, 1'b1, 1'b0, 19'h00200, 8'h00, 8'h5A, 19'h05555, 8'h78, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[14] = '{1'b1, 19'h05555, 8'h78, 1'b1, 1'b1, 1'b0, 19'h00200, 8'h00, 8'h5A, 19'h05555, 8'h78, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[15] = '{1'b0, 19'h05555, 8'h78, 1'b1, 1'b1, 1'b0, 19'h00200, 8'h00, 8'h5A, 19'h00010, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[16] = '{1'b0, 19'h05555, 8'h78, 1'b1, 1'b1, 1'b0, 19'h00200, 8'h00, 8'h5A, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[17] = '{1'b0, 19'h05555, 8'h78, 1'b1, 1'b1, 1'b0, 19'h00200, 8'h00, 8'h5A, 19'h00200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[18] = '{1'b0, 19'h05555, 8'h78, 1'b1, 1'b1, 1'b0, 19'h00200, 8'h00, 8'h5A, 19'h00200, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A};
        vecs[19] = '{1'b0, 19'h05555, 8'h78, 1'b1, 1'b0, 1'b0, 19'h00200, 8'h00, 8'h00, 19'h00200, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};

        // Reset held
        repeat (3) step();
        #3;
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_dq_oe", sram_dq_oe, 1'b0);
        step();
        rst = 1'b1;

        // Table: one row per clock cycle
        for (int i = 0; i < 20; i++) begin
            prog = vecs[i].prog; ld_add = vecs[i].ld_add; ld_do = vecs[i].ld_do; ld_we = vecs[i].ld_we;
            cpu_req = vecs[i].req; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr;
            cpu_wdata = vecs[i].wdata; din_tbl = vecs[i].din;
            #3;
            chk($sformatf("v%0d_addr", i), sram_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_dout", i), sram_dout, vecs[i].e_dout);
            chk($sformatf("v%0d_we_n", i), sram_we_n, vecs[i].e_we_n);
            chk($sformatf("v%0d_oe_n", i), sram_oe_n, vecs[i].e_oe_n);
            chk($sformatf("v%0d_dq_oe", i), sram_dq_oe, vecs[i].e_dq_oe);
            chk($sformatf("v%0d_cpu_ack", i), cpu_ack, vecs[i].e_ack);
            chk($sformatf("v%0d_vid_ack", i), vid_ack, 1'b0);
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
            step();
        end

        // Loader handoff: prog rises during a CPU read
        use_model = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00300;
        step();
        prog = 1'b1; ld_add = 19'h00ABC; ld_do = 8'h11; ld_we = 1'b1;
        step();
        step();
        #3;
        chk("handoff_ack", cpu_ack, 1'b1);
        chk("handoff_rdata", cpu_rdata, 8'h5A);
        step();
        #3;
        chk("handoff_pass_addr", sram_addr, 19'h00ABC);
        chk("handoff_pass_dq", sram_dq_oe, 1'b1);
        chk("handoff_pass_dout", sram_dout, 8'h11);
        n_ack = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            #3;
            if (cpu_ack) n_ack++;
        end
        chk("handoff_no_ack_in_prog", n_ack, 0);
        step();
        prog = 1'b0;
        run_cpu(1'b0, 19'h00300, 8'h00, ack_at, we_low, dq_hi);
        chk("prog_release_lat", ack_at, 3);
        chk("prog_release_rdata", cpu_rdata, 8'h5A);

        // Plain write outside the ROM window and one inside it
        run_cpu(1'b1, 19'h0F7FF, 8'h44, ack_at, we_low, dq_hi);
        chk("w_below_rom_ack", ack_at, 3);
        chk("w_below_rom_we_low", we_low, 1);
        chk("w_below_rom_dq", dq_hi, 4);
        run_cpu(1'b1, 19'h0F900, 8'h55, ack_at, we_low, dq_hi);
        chk("w_rom_ack", ack_at, 3);
        chk("w_rom_dq", dq_hi, 4);
`ifdef SRAM_ROM_WP_EN
        chk("w_rom_we_low", we_low, 0);
`else
        chk("w_rom_we_low", we_low, 1);
`endif

        // Contention: both held continuously, expect V,V,C,V,V,C
        exp_q = {"V", "V", "C", "V", "V", "C"};
        vid_addr = 19'h00040; cpu_addr = 19'h00081; cpu_we = 1'b0;
        vid_req = 1'b1; cpu_req = 1'b1;
        got = 0;
        dual = 0;
        for (int i = 0; i < 40; i++) begin
            #3;
            if (vid_ack && cpu_ack) dual++;
            if (vid_ack || cpu_ack) begin
                code = vid_ack ? 8'h56 : 8'h43;
                if (exp_q.size() > 0) chk($sformatf("order_%0d", got), code, exp_q.pop_front());
                else chk("extra_ack", 1, 0);
                if (vid_ack) chk($sformatf("vid_rdata_%0d", got), vid_rdata, 8'h1A);
                else         chk($sformatf("cpu_rdata_%0d", got), cpu_rdata, 8'hDB);
                got++;
            end
            if (got == 6) break;
            step();
        end
        step();
        vid_req = 1'b0; cpu_req = 1'b0;
        chk("contention_grants", got, 6);
        chk("contention_dual_ack", dual, 0);
        step();

        // Reset in the middle of a write strobe
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00020; cpu_wdata = 8'h99;
        step();
        step();
        #3;
        chk("rst_mid_pre_we", sram_we_n, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_mid_we_n", sram_we_n, 1'b1);
        chk("rst_mid_dq_oe", sram_dq_oe, 1'b0);
        chk("rst_mid_addr", sram_addr, 19'h00000);
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
        step();
        rst = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            #3;
            if (cpu_ack || vid_ack) n_ack++;
            step();
        end
        chk("rst_mid_no_ack", n_ack, 0);
        chk("rst_mid_idle_oe", sram_oe_n, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
